nbit_addsub_pipe: RTL and testbench

NBIT_ADDSUB_PIPE -- requirements
Module: nbit_addsub_pipe

---
 rtl/addsub_pkg.sv | 17 +
 rtl/nbit_addsub_core.sv | 31 +++
 rtl/nbit_addsub_pipe.sv | 108 ++++++++++
 tb/tb_nbit_addsub_pipe.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined N-bit add/subtract unit: operation
// encodings and a helper that tells the arithmetic core which operations subtract.
package addsub_pkg;

    typedef enum logic [1:0] {
        OP_ADD     = 2'b00,
        OP_SUB     = 2'b01,
        OP_ABSDIFF = 2'b10,
        OP_SUBSAT  = 2'b11
    } op_e;

    // Every mode except ADD computes a - b on the ripple chain.
    function automatic logic op_is_sub(input op_e op);
        return (op != OP_ADD);
    endfunction

endpackage

// File: rtl/nbit_addsub_core.sv
// Combinational N-bit ripple-carry adder/subtractor producing an N+1-bit raw
// result whose MSB is carry-out for add and borrow-out for subtract.
module nbit_addsub_core #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N:0]   raw
);

    logic [N-1:0] b_eff;
    logic [N-1:0] sum;

    assign b_eff = b ^ {N{sub}};

    // NOTE: always_comb assigns every output a default first so no path leaves a
    // variable unassigned, which would infer a latch.
    always_comb begin
        logic c;
        sum = '0;
        c   = sub;
        for (int i = 0; i < N; i++) begin
            sum[i] = a[i] ^ b_eff[i] ^ c;
            c      = (a[i] & b_eff[i]) | (c & (a[i] ^ b_eff[i]));
        end
        // a + ~b + 1 carries out exactly when a >= b, so invert to get a borrow.
        raw = {c ^ sub, sum};
    end

endmodule

// File: rtl/nbit_addsub_pipe.sv
// Two-stage valid/ready add/subtract pipeline: stage 1 holds the raw N+1-bit
// result and op, stage 2 holds post-processed y/cb/neg/zero.
module nbit_addsub_pipe
    import addsub_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  op_e          op,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] y,
    output logic         cb,
    output logic         neg,
    output logic         zero,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic         v1_q;
    logic [N:0]   raw_q;
    op_e          op_q;
    logic [N:0]   raw_d;

    logic         v2_q;
    logic [N-1:0] y_q,    y_d;
    logic         cb_q,   cb_d;
    logic         neg_q,  neg_d;
    logic         zero_q, zero_d;

    logic         load2;
    logic         load1;

    assign load2    = !v2_q || out_ready;
    assign load1    = !v1_q || load2;
    assign in_ready = !rst && load1;

    nbit_addsub_core #(.N(N)) u_core (
        .a   (a),
        .b   (b),
        .sub (op_is_sub(op)),
        .raw (raw_d)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q  <= 1'b0;
            raw_q <= '0;
            op_q  <= OP_ADD;
        end else if (load1) begin
            v1_q  <= in_valid;
            raw_q <= raw_d;
            op_q  <= op;
        end
    end

    always_comb begin
        y_d   = raw_q[N-1:0];
        cb_d  = raw_q[N];
        neg_d = 1'b0;
        case (op_q)
            OP_ADD, OP_SUB: y_d = raw_q[N-1:0];
            OP_ABSDIFF: begin
                // Magnitude of a negative difference always fits in N bits.
                y_d   = raw_q[N] ? (~raw_q[N-1:0] + ONE) : raw_q[N-1:0];
                neg_d = raw_q[N];
            end
            OP_SUBSAT: y_d = raw_q[N] ? '0 : raw_q[N-1:0];
            default:   y_d = raw_q[N-1:0];
        endcase
        zero_d = (y_d == '0);
    end

    // NOTE: result registers are reset too, because y/cb/neg/zero are visible
    // outputs that must read zero straight after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q   <= 1'b0;
            y_q    <= '0;
            cb_q   <= 1'b0;
            neg_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (load2) begin
            v2_q <= v1_q;
            // A bubble only drops out_valid; the previous result stays put.
            if (v1_q) begin
                y_q    <= y_d;
                cb_q   <= cb_d;
                neg_q  <= neg_d;
                zero_q <= zero_d;
            end
        end
    end

    assign y         = y_q;
    assign cb        = cb_q;
    assign neg       = neg_q;
    assign zero      = zero_q;
    assign out_valid = v2_q;

endmodule

// File: tb/tb_nbit_addsub_pipe.sv
// Directed self-checking bench for nbit_addsub_pipe (N=4) with a scoreboard
// queue filled on acceptance and drained on output handshakes.
module tb_nbit_addsub_pipe;
    import addsub_pkg::*;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] a;
    logic [N-1:0] b;
    op_e          op;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] y;
    logic         cb;
    logic         neg;
    logic         zero;
    logic         out_valid;
    logic         out_ready;

    typedef struct {
        logic [N-1:0] y;
        logic         cb;
        logic         neg;
        logic         zero;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    nbit_addsub_pipe #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .op        (op),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .cb        (cb),
        .neg       (neg),
        .zero      (zero),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic exp_t model(input int ia, input int ib, input op_e o);
        exp_t r;
        int   s;
        int   m;
        m     = 1 << N;
        r.cb  = 1'b0;
        r.neg = 1'b0;
        r.y   = '0;
        case (o)
            OP_ADD: begin
                s    = ia + ib;
                r.y  = N'(s % m);
                r.cb = (s >= m);
            end
            OP_SUB: begin
                s    = ia - ib + m;
                r.y  = N'(s % m);
                r.cb = (ia < ib);
            end
            OP_ABSDIFF: begin
                r.y   = N'((ia < ib) ? (ib - ia) : (ia - ib));
                r.cb  = (ia < ib);
                r.neg = (ia < ib);
            end
            default: begin
                r.y  = N'((ia < ib) ? 0 : (ia - ib));
                r.cb = (ia < ib);
            end
        endcase
        r.zero = (r.y == '0);
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", out_valid, 1'b0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_y",    y,    mon_e.y);
                check("sb_cb",   cb,   mon_e.cb);
                check("sb_neg",  neg,  mon_e.neg);
                check("sb_zero", zero, mon_e.zero);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input op_e top);
        logic got;
        got      = 1'b0;
        a        = ta;
        b        = tb_v;
        op       = top;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(model(int'(ta), int'(tb_v), top));
                got = 1'b1;
            end
            step();
        end
        in_valid = 1'b0;
        if (!got) check("send_timeout", got, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) step();
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        op_e          ro;

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = OP_ADD;
        out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_in_ready",  in_ready,  1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_y",         y,         '0);
        check("rst_cb",        cb,        1'b0);
        check("rst_neg",       neg,       1'b0);
        check("rst_zero",      zero,      1'b0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1'b1);
        step();

        // Latency: SUB 3-5
        send(4'd3, 4'd5, OP_SUB);
        @(negedge clk);
        check("lat1_out_valid", out_valid, 1'b0);
        step();
        @(negedge clk);
        check("lat2_out_valid", out_valid, 1'b1);
        check("sub35_y",    y,    4'd14);
        check("sub35_cb",   cb,   1'b1);
        check("sub35_neg",  neg,  1'b0);
        check("sub35_zero", zero, 1'b0);
        step();
        drain();

        // Directed corner cases, back to back
        send(4'd3,  4'd5,  OP_ABSDIFF);
        send(4'd0,  4'd15, OP_ABSDIFF);
        send(4'd2,  4'd9,  OP_SUBSAT);
        send(4'd9,  4'd8,  OP_ADD);
        send(4'd7,  4'd7,  OP_SUB);
        send(4'd5,  4'd5,  OP_ABSDIFF);
        send(4'd11, 4'd11, OP_SUBSAT);
        send(4'd15, 4'd15, OP_ADD);
        send(4'd0,  4'd1,  OP_SUB);
        send(4'd12, 4'd4,  OP_SUBSAT);
        drain();

        // Random operations with idle gaps
        for (int i = 0; i < 16; i++) begin
            ra = N'($urandom_range(0, 15));
            rb = N'($urandom_range(0, 15));
            ro = op_e'($urandom_range(0, 3));
            send(ra, rb, ro);
            if (i % 4 == 3) step();
        end
        drain();

        // Backpressure: fill both stages, hold output
        out_ready = 1'b0;
        send(4'd1, 4'd1, OP_ADD);
        send(4'd7, 4'd7, OP_SUB);
        a        = 4'd4;
        b        = 4'd6;
        op       = OP_ABSDIFF;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_y_hold",    y,         4'd2);
            check("bp_in_ready",  in_ready,  1'b0);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_resume", in_ready, 1'b1);
        if (in_ready) sb.push_back(model(4, 6, OP_ABSDIFF));
        step();
        in_valid = 1'b0;
        drain();

        // Reset with both stages full
        out_ready = 1'b0;
        send(4'd9, 4'd8, OP_ADD);
        send(4'd3, 4'd5, OP_SUB);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check("rst_full_in_ready", in_ready, 1'b0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_full_out_valid", out_valid, 1'b0);
        check("rst_full_y",         y,         '0);
        check("rst_full_in_ready1", in_ready,  1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            check("no_stale", out_valid, 1'b0);
        end
        step();
        send(4'd6, 4'd2, OP_SUBSAT);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
